qpu_exu_qflag_ctrl: RTL



---
 rtl/qpu_exu_qflag_ctrl_pkg.sv | 16 +
 rtl/qpu_exu_qflag_ctrl_lsb.sv | 22 ++
 rtl/qpu_exu_qflag_ctrl.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/qpu_exu_qflag_ctrl_pkg.sv
// Shared widths and helpers for the EXU measurement-flag controller.
package qpu_exu_qflag_ctrl_pkg;

    // Classical datapath width and real register-file index width.
    localparam int QPU_XLEN             = 32;
    localparam int QPU_RFIDX_REAL_WIDTH = 5;

    // Number of qubits tracked by the flag scoreboard.
    localparam int QPU_QUBIT_NUM        = 8;

    // Builds the FMR write-back word: flag in bit 0, upper bits zero.
    function automatic logic [QPU_XLEN-1:0] fmr_wbck_word(input logic flag);
        return {{(QPU_XLEN-1){1'b0}}, flag};
    endfunction

endpackage

// File: rtl/qpu_exu_qflag_ctrl_lsb.sv
// Lowest-set-bit encoder: returns the index of the lowest set bit of a mask
// and a flag telling whether any bit was set at all.
module qpu_exu_qflag_ctrl_lsb #(
    parameter int W  = 8,
    parameter int IW = 3
) (
    input  logic [W-1:0]  mask_i,
    output logic [IW-1:0] idx_o,
    output logic          nz_o
);

    // Scan from the top down so the lowest set bit is the one that sticks.
    always_comb begin
        idx_o = {IW{1'b0}};
        nz_o  = 1'b0;
        for (int i = W - 1; i >= 0; i--) begin
            idx_o = mask_i[i] ? IW'(i) : idx_o;
            nz_o  = nz_o | mask_i[i];
        end
    end

endmodule

// File: rtl/qpu_exu_qflag_ctrl.sv
// Measurement-flag scoreboard and FMR sequencer. Tracks in-flight measures,
// stores returned flags, stalls dependent instructions and writes an FMR
// result back to the classical register file.
module qpu_exu_qflag_ctrl
    import qpu_exu_qflag_ctrl_pkg::*;
#(
    parameter int QUBIT_NUM   = QPU_QUBIT_NUM,
    parameter int QIDX_W      = 3,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                            clk,
    input  logic                            rst_n,
    // dispatch side
    input  logic                            i_valid,
    output logic                            i_ready,
    input  logic                            i_measure,
    input  logic                            i_fmr,
    input  logic                            i_ffc,
    input  logic [QUBIT_NUM-1:0]            i_qmask,
    input  logic [QPU_RFIDX_REAL_WIDTH-1:0] i_rdidx,
    // measurement return
    input  logic                            meas_res_valid,
    input  logic [QIDX_W-1:0]               meas_res_qidx,
    input  logic                            meas_res_val,
    // FMR write-back
    output logic                            o_fmr_wbck_valid,
    input  logic                            o_fmr_wbck_ready,
    output logic [QPU_RFIDX_REAL_WIDTH-1:0] o_fmr_wbck_rdidx,
    output logic [QPU_XLEN-1:0]             o_fmr_wbck_data,
    // status
    output logic [QUBIT_NUM-1:0]            o_qflag,
    output logic [QUBIT_NUM-1:0]            o_qflag_vld,
    output logic [QUBIT_NUM-1:0]            o_pend_mask,
    output logic                            o_busy,
    output logic                            o_timeout_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Counter only needs to reach TIMEOUT_CYC-1.
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        (TIMEOUT_CYC != 0) ? CNT_W'(TIMEOUT_CYC - 1) : {CNT_W{1'b0}};

    state_e                          state_q, state_d;
    logic [QUBIT_NUM-1:0]            pend_q, pend_d;
    logic [QUBIT_NUM-1:0]            vld_q, vld_d;
    logic [QUBIT_NUM-1:0]            flag_q, flag_d;
    logic [QIDX_W-1:0]               qidx_q, qidx_d;
    logic [QPU_RFIDX_REAL_WIDTH-1:0] rdidx_q, rdidx_d;
    logic                            rdata_q, rdata_d;
    logic [CNT_W-1:0]                cnt_q, cnt_d;
    logic                            terr_q, terr_d;

    logic                            accept_s;
    logic [QUBIT_NUM-1:0]            res_sel_s;
    logic [QUBIT_NUM-1:0]            res_hit_s;
    logic [QUBIT_NUM-1:0]            meas_set_s;
    logic [QIDX_W-1:0]               lsb_idx_s;
    logic                            lsb_nz_s;

    qpu_exu_qflag_ctrl_lsb #(
        .W  (QUBIT_NUM),
        .IW (QIDX_W)
    ) u_lsb (
        .mask_i (i_qmask),
        .idx_o  (lsb_idx_s),
        .nz_o   (lsb_nz_s)
    );

    // Dispatch handshake: one FMR at a time, and no measure/FFC touching a
    // qubit whose measurement is still in flight.
    always_comb begin
        i_ready = 1'b1;
        if (state_q != ST_IDLE) begin
            i_ready = 1'b0;
        end else if (i_measure && (|(i_qmask & pend_q))) begin
            i_ready = 1'b0;
        end else if (i_ffc && (|(i_qmask & pend_q))) begin
            i_ready = 1'b0;
        end else begin
            i_ready = 1'b1;
        end
    end

    assign accept_s = i_valid & i_ready;

    // Decode the result strobe; only results for pending qubits count.
    always_comb begin
        res_sel_s = {QUBIT_NUM{1'b0}};
        for (int q = 0; q < QUBIT_NUM; q++) begin
            res_sel_s[q] = meas_res_valid && (meas_res_qidx == QIDX_W'(q));
        end
        res_hit_s  = res_sel_s & pend_q;
        meas_set_s = (accept_s && i_measure) ? i_qmask : {QUBIT_NUM{1'b0}};
    end

    // Scoreboard update: retire results first, then mark newly issued measures.
    always_comb begin
        pend_d = (pend_q & ~res_hit_s) | meas_set_s;
        vld_d  = (vld_q | res_hit_s) & ~meas_set_s;
        flag_d = (flag_q & ~res_hit_s) | (res_hit_s & {QUBIT_NUM{meas_res_val}});
    end

    // FMR sequencer: resolve immediately when the flag is known, otherwise wait
    // for the result or the timeout, then hold the write-back until accepted.
    always_comb begin
        state_d = state_q;
        qidx_d  = qidx_q;
        rdidx_d = rdidx_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        terr_d  = terr_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s && i_fmr) begin
                    qidx_d  = lsb_idx_s;
                    rdidx_d = i_rdidx;
                    cnt_d   = {CNT_W{1'b0}};
                    if (!lsb_nz_s) begin
                        rdata_d = 1'b0;
                        state_d = ST_RESP;
                    end else if (!pend_q[lsb_idx_s]) begin
                        rdata_d = flag_q[lsb_idx_s];
                        state_d = ST_RESP;
                    end else if (res_hit_s[lsb_idx_s]) begin
                        rdata_d = meas_res_val;
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (res_hit_s[qidx_q]) begin
                    rdata_d = meas_res_val;
                    state_d = ST_RESP;
                end else if ((TIMEOUT_CYC != 0) && (cnt_q == CNT_LAST)) begin
                    terr_d  = 1'b1;
                    rdata_d = 1'b0;
                    state_d = ST_RESP;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (o_fmr_wbck_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; asynchronous reset drops any in-flight FMR and pending state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pend_q  <= {QUBIT_NUM{1'b0}};
            vld_q   <= {QUBIT_NUM{1'b0}};
            flag_q  <= {QUBIT_NUM{1'b0}};
            qidx_q  <= {QIDX_W{1'b0}};
            rdidx_q <= {QPU_RFIDX_REAL_WIDTH{1'b0}};
            rdata_q <= 1'b0;
            cnt_q   <= {CNT_W{1'b0}};
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            vld_q   <= vld_d;
            flag_q  <= flag_d;
            qidx_q  <= qidx_d;
            rdidx_q <= rdidx_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            terr_q  <= terr_d;
        end
    end

    assign o_fmr_wbck_valid = (state_q == ST_RESP);
    assign o_fmr_wbck_rdidx = rdidx_q;
    assign o_fmr_wbck_data  = fmr_wbck_word(rdata_q);
    assign o_qflag          = flag_q;
    assign o_qflag_vld      = vld_q;
    assign o_pend_mask      = pend_q;
    assign o_busy           = (|pend_q) || (state_q != ST_IDLE);
    assign o_timeout_err    = terr_q;

endmodule
